// File: rtl/lsu_ldq.sv
// Load/store unit with an in-order queue of up to LDQ_DEPTH outstanding loads; load result is registered one cycle after its response.
// Stores never wait on the queue; loads stall on mem_req_ready or a full queue; writeback holds the head entry while wb_ready is low.
module lsu_ldq #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 4,
    parameter int LDQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_is_load,
    input  logic [2:0]                req_op,
    input  logic [XLEN-1:0]           req_addr,
    input  logic [XLEN-1:0]           req_wdata,
    input  logic [RF_ADDR_W-1:0]      req_rd,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [XLEN-1:0]           mem_addr,
    output logic [3:0]                mem_we,
    output logic [XLEN-1:0]           mem_wdata,
    input  logic                      mem_rsp_valid,
    input  logic [XLEN-1:0]           mem_rsp_data,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [RF_ADDR_W-1:0]      wb_rd,
    output logic [XLEN-1:0]           wb_data,
    output logic [(2**RF_ADDR_W)-1:0] pend_rd_mask,
    output logic                      misalign_err,
    output logic [XLEN-1:0]           err_addr,
    output logic                      busy
);

    localparam int PTR_W = $clog2(LDQ_DEPTH);
    localparam int CNT_W = $clog2(LDQ_DEPTH + 1);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [2:0]           op;
        logic [1:0]           off;
    } ldq_meta_t;

    // Queue storage: control bits are reset, payload is not
    ldq_meta_t             r_meta [LDQ_DEPTH];
    logic [XLEN-1:0]       r_data [LDQ_DEPTH];
    logic [LDQ_DEPTH-1:0]  r_vld;
    logic [LDQ_DEPTH-1:0]  r_dv;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [PTR_W-1:0]      r_rsp;
    logic [CNT_W-1:0]      r_count;
    logic                  r_misalign;
    logic [XLEN-1:0]       r_err_addr;

    logic [1:0]            w_size;
    logic                  w_misalign;
    logic                  w_full;
    logic                  w_alloc;
    logic                  w_fill;
    logic                  w_pop;
    logic                  w_head_rdy;
    logic                  w_head_silent;
    ldq_meta_t             w_head;
    logic [XLEN-1:0]       w_head_word;
    logic [XLEN-1:0]       w_shift;

    assign w_size     = req_op[1:0];
    assign w_misalign = ((w_size == SZ_H) && req_addr[0]) ||
                        ((w_size == SZ_W) && (req_addr[1:0] != 2'b00));
    // Full is taken from the registered count, so a same-cycle pop does not free a slot
    assign w_full     = (r_count == CNT_W'(LDQ_DEPTH));

    always_comb begin
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        if (w_misalign) begin
            req_ready = 1'b1;
        end else if (req_is_load) begin
            mem_req_valid = req_valid && !w_full;
            req_ready     = mem_req_ready && !w_full;
        end else begin
            mem_req_valid = req_valid;
            req_ready     = mem_req_ready;
        end
    end

    assign mem_addr = {req_addr[XLEN-1:2], 2'b00};

    always_comb begin
        mem_we    = 4'b0000;
        mem_wdata = req_wdata;
        case (w_size)
            SZ_B: begin
                mem_wdata = {(XLEN/8){req_wdata[7:0]}};
                mem_we    = 4'b0001 << req_addr[1:0];
            end
            SZ_H: begin
                mem_wdata = {(XLEN/16){req_wdata[15:0]}};
                mem_we    = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: mem_we = 4'b1111;
        endcase
        if (req_is_load) begin
            mem_we = 4'b0000;
        end
    end

    assign w_alloc = req_valid && req_ready && req_is_load && !w_misalign;
    // A slot allocated this cycle is not yet valid, so it can never be filled in its own accept cycle
    assign w_fill  = mem_rsp_valid && r_vld[r_rsp] && !r_dv[r_rsp];

    assign w_head        = r_meta[r_head];
    assign w_head_word   = r_data[r_head];
    assign w_head_rdy    = r_vld[r_head] && r_dv[r_head];
    assign w_head_silent = (w_head.rd == '0);
    assign w_pop         = w_head_rdy && (w_head_silent || wb_ready);

    assign wb_valid = w_head_rdy && !w_head_silent;
    assign wb_rd    = w_head.rd;
    assign w_shift  = w_head_word >> {w_head.off, 3'b000};

    always_comb begin
        case (w_head.op)
            OP_LB:   wb_data = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
            OP_LH:   wb_data = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
            OP_LBU:  wb_data = {{(XLEN-8){1'b0}}, w_shift[7:0]};
            OP_LHU:  wb_data = {{(XLEN-16){1'b0}}, w_shift[15:0]};
            default: wb_data = w_head_word;
        endcase
    end

    always_comb begin
        pend_rd_mask = '0;
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if (r_vld[i]) begin
                pend_rd_mask[w_rd_of(i)] = 1'b1;
            end
        end
        pend_rd_mask[0] = 1'b0;
    end

    function automatic logic [RF_ADDR_W-1:0] w_rd_of(input int idx);
        return r_meta[idx].rd;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld      <= '0;
            r_dv       <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_rsp      <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            r_err_addr <= '0;
        end else begin
            if (w_alloc) begin
                r_vld[r_tail] <= 1'b1;
                r_dv[r_tail]  <= 1'b0;
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (w_fill) begin
                r_dv[r_rsp] <= 1'b1;
                r_rsp       <= r_rsp + PTR_W'(1);
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_dv[r_head]  <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            r_count    <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
            r_misalign <= req_valid && w_misalign;
            if (req_valid && w_misalign) begin
                r_err_addr <= req_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_meta[r_tail] <= '{rd: req_rd, op: req_op, off: req_addr[1:0]};
        end
        if (w_fill) begin
            r_data[r_rsp] <= mem_rsp_data;
        end
    end

    assign misalign_err = r_misalign;
    assign err_addr     = r_err_addr;
    assign busy         = (r_count != '0);

endmodule

// File: tb/tb_lsu_ldq.sv
// Self-checking bench for lsu_ldq: scoreboard of expected writebacks, in-order memory responder with per-load latency.
module tb_lsu_ldq;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_load = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_rd = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [15:0] pend_rd_mask;
    logic        misalign_err;
    logic [31:0] err_addr;
    logic        busy;

    logic wb_fix = 1'b1;
    logic wb_rnd = 1'b1;
    logic rand_wb = 1'b0;
    logic rsp_hold = 1'b1;
    assign wb_ready = rand_wb ? wb_rnd : wb_fix;

    typedef struct packed { logic [3:0] rd; logic [31:0] data; } sb_t;
    typedef struct { logic [31:0] word; int due; } rsp_t;
    sb_t  sb_q[$];
    rsp_t rsp_q[$];
    sb_t  mon_e;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_rsp_cyc = 0;

    lsu_ldq #(.XLEN(32), .RF_ADDR_W(4), .LDQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .pend_rd_mask(pend_rd_mask), .misalign_err(misalign_err), .err_addr(err_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            LB:      return {{24{b[7]}}, b};
            LH:      return {{16{h[15]}}, h};
            LBU:     return {24'h0, b};
            LHU:     return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // In-order memory: the head response goes out once its due cycle is reached
    always @(posedge clk) begin
        #1;
        mem_rsp_valid = 1'b0;
        if (!rsp_hold && rsp_q.size() > 0 && cyc >= rsp_q[0].due) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = rsp_q[0].word;
            void'(rsp_q.pop_front());
            last_rsp_cyc  = cyc;
        end
    end

    always @(posedge clk) begin
        #1;
        wb_rnd = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst && wb_valid) begin
            check("wb_rd_nonzero", 32'(wb_rd == 4'd0), 32'd0);
            if (wb_ready) begin
                if (sb_q.size() == 0) begin
                    check("wb_spurious", 32'(wb_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                    check("wb_data", wb_data, mon_e.data);
                end
            end
        end
    end

    task automatic drive_load(input logic [2:0] op, input logic [31:0] a, input logic [3:0] rd);
        req_valid = 1'b1; req_is_load = 1'b1; req_op = op; req_addr = a; req_rd = rd;
        req_wdata = $urandom;
    endtask

    task automatic wait_accept(input logic [3:0] rd, input logic [31:0] word, input logic [31:0] expd,
                               input int lat, output int waited);
        int   t;
        sb_t  e;
        rsp_t r;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("ld_accept", 32'(req_ready), 32'd1);
        check("ld_mem_valid", 32'(mem_req_valid), 32'd1);
        check("ld_mem_addr", mem_addr, {req_addr[31:2], 2'b00});
        check("ld_mem_we", 32'(mem_we), 32'd0);
        if (req_ready) begin
            if (rd != 4'd0) begin
                e.rd = rd; e.data = expd;
                sb_q.push_back(e);
            end
            r.word = word; r.due = cyc + lat;
            rsp_q.push_back(r);
        end
        waited = t;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] exp_we, input logic [31:0] exp_wd);
        req_valid = 1'b1; req_is_load = 1'b0; req_op = op; req_addr = a; req_wdata = d; req_rd = 4'd0;
        @(negedge clk);
        check("st_mem_valid", 32'(mem_req_valid), 32'd1);
        check("st_req_ready", 32'(req_ready), 32'd1);
        check("st_mem_we", 32'(mem_we), 32'(exp_we));
        check("st_mem_wdata", mem_wdata, exp_wd);
        check("st_mem_addr", mem_addr, {a[31:2], 2'b00});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_sb", 32'(sb_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [2:0]  ml_op  [4] = '{LW, LH, LH, LW};
    logic        ml_ld  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ml_adr [4] = '{32'h102, 32'h101, 32'h201, 32'h306};

    initial begin
        int          t;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] w;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_pend", 32'(pend_rd_mask), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // LW with three-cycle memory latency
        rsp_hold = 1'b0;
        drive_load(LW, 32'h100, 4'd5);
        wait_accept(4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 3, t);
        @(negedge clk);
        check("t1_pend_set", 32'(pend_rd_mask), 32'h0020);
        check("t1_busy", 32'(busy), 32'd1);
        t = 0;
        while (!wb_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t1_wb_seen", 32'(wb_valid), 32'd1);
        check("t1_wb_lat", 32'(cyc - last_rsp_cyc), 32'd1);
        check("t1_pend_hold", 32'(pend_rd_mask), 32'h0020);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_pend_clr", 32'(pend_rd_mask), 32'd0);
        check("t1_busy_clr", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // rd=0 load occupies the queue but never raises a pending bit or wb_valid
        rsp_hold = 1'b1;
        drive_load(LW, 32'h104, 4'd0);
        wait_accept(4'd0, 32'h12345678, 32'h0, 1, t);
        @(negedge clk);
        check("x0_pend", 32'(pend_rd_mask), 32'd0);
        check("x0_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rsp_hold = 1'b0;
        drain();

        // Sub-word loads on 0x80FF1234, pipelined with one-cycle latency
        drive_load(LB, 32'h103, 4'd6);
        wait_accept(4'd6, 32'h80FF1234, 32'hFFFFFF80, 1, t);
        drive_load(LBU, 32'h103, 4'd7);
        wait_accept(4'd7, 32'h80FF1234, 32'h00000080, 1, t);
        drive_load(LH, 32'h102, 4'd8);
        mem_req_ready = 1'b0;
        @(negedge clk);
        check("mrdy_lo_ready", 32'(req_ready), 32'd0);
        check("mrdy_lo_valid", 32'(mem_req_valid), 32'd1);
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        wait_accept(4'd8, 32'h80FF1234, 32'hFFFF80FF, 1, t);
        drive_load(LHU, 32'h102, 4'd9);
        wait_accept(4'd9, 32'h80FF1234, 32'h000080FF, 2, t);
        drive_load(LB, 32'h100, 4'd10);
        wait_accept(4'd10, 32'h80FF1234, 32'h00000034, 1, t);
        drain();

        // Store lanes
        do_store(LB, 32'h101, 32'h000000AB, 4'b0010, 32'hABABABAB);
        do_store(LH, 32'h102, 32'h00001234, 4'b1100, 32'h12341234);
        do_store(LB, 32'h100, 32'hFFFFFFCD, 4'b0001, 32'hCDCDCDCD);
        do_store(LH, 32'h100, 32'h00005678, 4'b0011, 32'h56785678);
        do_store(LW, 32'h104, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
        req_valid = 1'b1; req_is_load = 1'b0; req_op = LW; req_addr = 32'h108;
        mem_req_ready = 1'b0;
        @(negedge clk);
        check("st_mrdy_lo_ready", 32'(req_ready), 32'd0);
        check("st_mrdy_lo_valid", 32'(mem_req_valid), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_req_ready = 1'b1;

        // Fill the queue, fifth load stalls, store passes, drain in order with wb held
        rsp_hold = 1'b1;
        wb_fix = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_load(LW, 32'h200 + 32'(4*i), 4'(i));
            wait_accept(4'(i), 32'h11111111 * i, 32'h11111111 * i, 1, t);
        end
        drive_load(LW, 32'h300, 4'd5);
        @(negedge clk);
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_mem_valid", 32'(mem_req_valid), 32'd0);
        check("full_pend", 32'(pend_rd_mask), 32'h001E);
        check("full_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        do_store(LW, 32'h400, 32'h55AA55AA, 4'b1111, 32'h55AA55AA);
        drive_load(LW, 32'h300, 4'd5);
        rsp_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        check("hold_wb_valid", 32'(wb_valid), 32'd1);
        check("hold_wb_rd", 32'(wb_rd), 32'd1);
        @(posedge clk); #1;
        wb_fix = 1'b1;
        @(negedge clk);
        check("pop_full_ready", 32'(req_ready), 32'd0);
        check("pop_full_wb", 32'(wb_valid), 32'd1);
        @(posedge clk); #1;
        wait_accept(4'd5, 32'h55555555, 32'h55555555, 2, t);
        check("ld5_prompt", 32'(t), 32'd0);
        drain();

        // Misaligned requests: no memory request, error pulse next cycle
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_is_load = ml_ld[i]; req_op = ml_op[i];
            req_addr = ml_adr[i]; req_rd = 4'd9; req_wdata = 32'h0;
            @(negedge clk);
            check("mis_mem_valid", 32'(mem_req_valid), 32'd0);
            check("mis_req_ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            check("mis_err", 32'(misalign_err), 32'd1);
            check("mis_err_addr", err_addr, ml_adr[i]);
            check("mis_busy", 32'(busy), 32'd0);
            check("mis_pend", 32'(pend_rd_mask), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("mis_pulse_end", 32'(misalign_err), 32'd0);
        check("mis_addr_kept", err_addr, 32'h306);
        @(posedge clk); #1;

        // Reset with two loads in flight; their late responses must be ignored
        rsp_hold = 1'b1;
        drive_load(LW, 32'h500, 4'd10);
        wait_accept(4'd10, 32'hAAAA0001, 32'hAAAA0001, 1, t);
        drive_load(LW, 32'h504, 4'd11);
        wait_accept(4'd11, 32'hAAAA0002, 32'hAAAA0002, 1, t);
        @(negedge clk);
        check("rst_inflight_pend", 32'(pend_rd_mask), 32'h0C00);
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        rsp_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("late_wb_valid", 32'(wb_valid), 32'd0);
            check("late_pend", 32'(pend_rd_mask), 32'd0);
            check("late_busy", 32'(busy), 32'd0);
        end
        check("late_err_addr", err_addr, 32'd0);
        @(posedge clk); #1;
        drive_load(LW, 32'h600, 4'd12);
        wait_accept(4'd12, 32'h0BADF00D, 32'h0BADF00D, 2, t);
        drain();

        // Randomised loads with random latency and writeback backpressure
        rand_wb = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: op = LB;
                1: op = LH;
                2: op = LW;
                3: op = LBU;
                default: op = LHU;
            endcase
            a = 32'h1000 + 32'(4 * $urandom_range(0, 255));
            if (op[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
            else if (op[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
            w = $urandom;
            drive_load(op, a, 4'($urandom_range(0, 15)));
            wait_accept(req_rd, w, ld_model(op, a[1:0], w), $urandom_range(1, 4), t);
        end
        drain();
        rand_wb = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
